// File: rtl/fb_port_arbiter_if.sv
// Framebuffer port arbiter bus bundle.
// Groups the display read channel, host write channel, fill-engine control,
// the single-port RAM interface and the drop counter.
//   slave  : the arbiter side (fb_port_arbiter)
//   master : the surrounding system (display, host, RAM)
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  // display read request / return
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  // host write channel
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  // fill engine control
  logic              clr_start;
  logic [DATA_W-1:0] clr_colour;
  logic              clr_busy;
  logic              clr_done;
  // single-port synchronous RAM, 1-cycle read latency
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;
  // dropped out-of-range host writes
  logic [7:0]        drop_cnt;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data,
           clr_start, clr_colour, mem_q,
    output rd_ready, rd_valid, rd_data, wr_ready,
           clr_busy, clr_done, mem_addr, mem_d, mem_we, drop_cnt
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data,
           clr_start, clr_colour, mem_q,
    input  rd_ready, rd_valid, rd_data, wr_ready,
           clr_busy, clr_done, mem_addr, mem_d, mem_we, drop_cnt
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM port arbiter.
// Shares one single-port synchronous RAM between a display reader (highest
// priority), a host writer (protected from starvation by a streak limit) and a
// fill engine that paints the whole framebuffer with one colour in idle slots.
// Ports:
//   sys_clk : single clock, rising edge
//   reset   : asynchronous, active-low
//   bus     : fb_port_arbiter_if.slave (read, write, fill, RAM, drop counter)
module fb_port_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int FB_SIZE      = 480000,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  fb_port_arbiter_if.slave     bus
);

  localparam int                STREAK_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
  localparam logic [ADDR_W:0]   FB_END     = (ADDR_W + 1)'(FB_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_SIZE - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_e;

  fill_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0]   colour_q, colour_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_d_q, mem_d_d;
  logic                mem_we_q, mem_we_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;
  logic [7:0]          drop_q, drop_d;

  logic starve;
  logic rd_ready;
  logic wr_ready;
  logic rd_acc;
  logic wr_acc;
  logic wr_in_range;
  logic fill_issue;

  // Handshakes depend only on inputs and the streak register. When the streak
  // is saturated and a write waits, the read is refused and the write admitted,
  // so read and write acceptance are mutually exclusive by construction.
  always_comb begin
    starve      = (streak_q == STREAK_MAX);
    rd_ready    = !(bus.wr_valid && starve);
    wr_ready    = !bus.rd_req || starve;
    rd_acc      = bus.rd_req && rd_ready;
    wr_acc      = bus.wr_valid && wr_ready;
    wr_in_range = ({1'b0, bus.wr_addr} < FB_END);
  end

  // Datapath: one RAM access per cycle, read > host write > fill.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    mem_we_d   = 1'b0;
    drop_d     = drop_q;
    streak_d   = streak_q;
    fill_issue = 1'b0;
    rd_pend_d  = rd_acc;
    rd_valid_d = rd_pend_q;

    if (!bus.wr_valid || wr_acc) begin
      streak_d = '0;
    end else if (rd_acc && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end

    if (rd_acc) begin
      mem_addr_d = bus.rd_addr;
    end else if (wr_acc) begin
      if (wr_in_range) begin
        mem_addr_d = bus.wr_addr;
        mem_d_d    = bus.wr_data;
        mem_we_d   = 1'b1;
      end else if (drop_q != '1) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (state_q == S_FILL) begin
      fill_issue = 1'b1;
      mem_addr_d = fill_addr_q;
      mem_d_d    = colour_q;
      mem_we_d   = 1'b1;
    end
  end

  // Fill FSM next state: the address only advances on an issued fill write.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    colour_d    = colour_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.clr_start) begin
          state_d     = S_FILL;
          fill_addr_d = '0;
          colour_d    = bus.clr_colour;
        end
      end
      S_FILL: begin
        if (fill_issue) begin
          if (fill_addr_q == LAST_ADDR) begin
            state_d     = S_IDLE;
            fill_addr_d = '0;
            done_d      = 1'b1;
          end else begin
            fill_addr_d = fill_addr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      fill_addr_q <= '0;
      colour_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      colour_q    <= colour_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      streak_q   <= '0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
      mem_we_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      streak_q   <= streak_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      mem_we_q   <= mem_we_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.rd_ready = rd_ready;
  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = rd_valid_q;
  // RAM output register already lines up with rd_valid two cycles after accept
  assign bus.rd_data  = bus.mem_q;
  assign bus.clr_busy = (state_q == S_FILL);
  assign bus.clr_done = done_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_d    = mem_d_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, framebuffer address width.
REQ-002 SHALL have parameter DATA_W, default 8, colour-index width.
REQ-003 SHALL have parameter FB_SIZE, default 480000, number of valid framebuffer locations (800x600).
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, maximum consecutive read grants while a write waits.
REQ-005 SHALL have port sys_clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports rd_req in 1, rd_addr in ADDR_W, rd_ready out 1: display read request channel.
REQ-008 SHALL have ports rd_valid out 1, rd_data out DATA_W: display read return.
REQ-009 SHALL have ports wr_valid in 1, wr_addr in ADDR_W, wr_data in DATA_W, wr_ready out 1: host write channel.
REQ-010 SHALL have ports clr_start in 1, clr_colour in DATA_W, clr_busy out 1, clr_done out 1: fill engine control.
REQ-011 SHALL have ports mem_addr out ADDR_W, mem_d out DATA_W, mem_we out 1, mem_q in DATA_W: single-port synchronous RAM, 1-cycle read latency.
REQ-012 SHALL have port drop_cnt out 8: count of dropped out-of-range writes.

Function
REQ-013 SHALL grant at most one RAM access per cycle; priority: read, then host write, then fill.
REQ-014 SHALL accept a read in a cycle where rd_req && rd_ready; rd_ready = !(wr_valid && streak == STARVE_LIMIT).
REQ-015 SHALL accept a host write in a cycle where wr_valid && wr_ready; wr_ready = !rd_req || streak == STARVE_LIMIT.
REQ-016 SHALL hold a streak counter: +1 when a read is accepted while wr_valid is high; cleared when a write is accepted or wr_valid is low; never exceeds STARVE_LIMIT.
REQ-017 SHALL register mem_addr, mem_d, mem_we one cycle after acceptance (accept at N -> RAM access at N+1).
REQ-018 SHALL assert rd_valid for exactly one cycle at N+2 for a read accepted at N, with rd_data = mem_q; back-to-back reads yield back-to-back rd_valid in order.
REQ-019 SHALL, for an accepted host write with wr_addr >= FB_SIZE, hold mem_we low, not touch RAM, and increment drop_cnt, saturating at 255.
REQ-020 SHALL implement fill FSM states IDLE and FILL; IDLE->FILL on clr_start; FILL->IDLE after writing address FB_SIZE-1.
REQ-021 SHALL, in FILL, write clr_colour (captured at clr_start) to fill address, starting at 0, only in cycles with no read or host write accepted; address increments by 1 only when a fill write is issued.
REQ-022 SHALL ignore clr_start while clr_busy is high.
REQ-023 SHALL drive clr_busy high for every cycle in FILL; clr_done SHALL pulse one cycle in the cycle after the final fill write is issued, coincident with clr_busy falling.
REQ-024 SHALL hold mem_we low and mem_d unchanged in cycles with no write issued; mem_addr holds its last value.
REQ-025 SHALL let host writes during FILL proceed; a later fill write to the same address overwrites them.

Reset
REQ-026 SHALL, while reset is low, force mem_we=0, mem_addr=0, mem_d=0, rd_valid=0, rd_data pipeline flag cleared, clr_busy=0, clr_done=0, drop_cnt=0, streak=0, fill FSM=IDLE, fill address=0.
REQ-027 SHALL, on reset assertion mid-fill or with reads in flight, abandon them with no rd_valid or clr_done emitted afterwards.
REQ-028 SHALL leave rd_ready/wr_ready purely combinational from inputs and streak, so they are valid immediately after reset release.

Verification
REQ-029 Read pipe: rd_req=1, rd_addr=5,6,7 on consecutive cycles, wr_valid=0 -> mem_addr 5,6,7 from N+1, rd_valid high N+2..N+4 with RAM contents of 5,6,7.
REQ-030 Starvation: rd_req held 1, wr_valid held 1, wr_addr=100 -> exactly 8 reads accepted, then wr_ready=1 and mem_we=1 at addr 100 one cycle later, streak cleared.
REQ-031 Drop: write wr_addr=480000 -> mem_we stays 0, drop_cnt 0->1; 300 such writes -> drop_cnt=255.
REQ-032 Fill: clr_start with clr_colour=8'h2A, no other traffic -> clr_busy for 480000 cycles, addresses 0..479999 written 8'h2A, clr_done one cycle, second clr_start during busy ignored.
REQ-033 Fill yield: continuous rd_req during FILL -> no fill writes, fill address frozen; release rd_req -> fill resumes at the frozen address.
REQ-034 Reset mid-fill: assert reset at fill address 1000 -> all outputs at REQ-026 values, no clr_done; new clr_start restarts at address 0.
